// File: rtl/key_expander.sv
// AES-128 round-key scheduler: accepts a cipher key and fills a table with ROUNDS round keys, one per cycle.
// Optional build macro KEY_EXPANDER_ZEROIZE_EN adds a zeroize input that wipes the table and aborts expansion.

module key_maker (
  input  logic [127:0] prev_key,
  input  logic [3:0]   round,
  output logic [127:0] next_key
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

  always_comb begin
    w0   = prev_key[127:96];
    w1   = prev_key[95:64];
    w2   = prev_key[63:32];
    w3   = prev_key[31:0];
    // RotWord then SubWord on the last word, folded with the round constant
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
           ^ {rcon(round), 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

endmodule

module key_expander #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef KEY_EXPANDER_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic [0:127] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [0:127] rd_key
);

  typedef enum logic {IDLE, EXPAND} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  state_t       state, state_nxt;
  logic [3:0]   round_cnt;
  logic [127:0] slots [0:ROUNDS];
  logic [127:0] prev_key, next_key;
  logic         accept, step, last, clear;

`ifdef KEY_EXPANDER_ZEROIZE_EN
  assign clear = zeroize;
`else
  assign clear = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    key_ready = (state == IDLE);
    busy      = (state == EXPAND);
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            accept    = 1'b1;
            state_nxt = EXPAND;
          end
        end
        EXPAND: begin
          step = 1'b1;
          if (round_cnt == LAST_ROUND) begin
            last      = 1'b1;
            state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counter holds at ROUNDS after the final write rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt  <= 4'd0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else if (clear) begin
      round_cnt  <= 4'd0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        round_cnt  <= 4'd1;
        keys_valid <= 1'b0;
      end else if (step) begin
        if (last) keys_valid <= 1'b1;
        else      round_cnt  <= round_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ROUNDS; i++) slots[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i <= ROUNDS; i++) slots[i] <= '0;
    end else if (accept) begin
      slots[0] <= key_in;
    end else if (step) begin
      for (int i = 1; i <= ROUNDS; i++)
        if (round_cnt == 4'(i)) slots[i] <= next_key;
    end
  end

  always_comb begin
    prev_key = '0;
    for (int i = 0; i < ROUNDS; i++)
      if (round_cnt == 4'(i + 1)) prev_key = slots[i];
  end

  key_maker u_key_maker (
    .prev_key (prev_key),
    .round    (round_cnt),
    .next_key (next_key)
  );

  // Indices beyond the schedule read as zero
  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= ROUNDS; i++)
      if (rd_idx == 4'(i)) rd_key = slots[i];
  end

endmodule

// File: doc/key_expander.md
KEY_EXPANDER -- requirements
Module: key_expander

Interface
REQ-001 Parameter ROUNDS, default 10, number of round keys generated after the cipher key; legal range 1..10.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 key_in  input  [0:127]  cipher key, MSB-first bit order.
REQ-005 key_valid  input  1  key_in offered.
REQ-006 key_ready  output  1  block can accept a key.
REQ-007 busy  output  1  expansion in progress.
REQ-008 done  output  1  one-cycle pulse when all round keys are stored.
REQ-009 keys_valid  output  1  level; the key table holds a complete schedule.
REQ-010 rd_idx  input  [3:0]  round-key table read index.
REQ-011 rd_key  output  [0:127]  combinational read of table slot rd_idx.

Function
REQ-012 States SHALL be IDLE and EXPAND; key_ready = (state==IDLE); busy = (state==EXPAND).
REQ-013 Accept edge (A0) = rising edge with key_valid && key_ready: slot0 <= key_in, round counter <= 1, keys_valid <= 0, state -> EXPAND.
REQ-014 key_valid while not ready SHALL be ignored; key_in is sampled only at A0.
REQ-015 Each EXPAND cycle SHALL write slot[r] <= key_maker(previous_key=slot[r-1], round=r), then r <= r+1; exactly one slot per cycle.
REQ-016 The per-round computation SHALL be the existing key_maker module, one instance, combinational, with its input muxed from slot[r-1].
REQ-017 slot[ROUNDS] SHALL be written at edge A0+ROUNDS; at that same edge state -> IDLE, keys_valid <= 1, done <= 1.
REQ-018 done SHALL be high exactly one cycle (deasserted at A0+ROUNDS+1).
REQ-019 A new key SHALL be acceptable in the cycle done is high; that accept clears keys_valid and restarts at slot0; done still falls on schedule.
REQ-020 keys_valid SHALL stay high until the next accept edge or reset.
REQ-021 rd_key SHALL be slot[rd_idx] for rd_idx <= ROUNDS, and all-zero for rd_idx > ROUNDS.
REQ-022 Reads during EXPAND SHALL return current slot contents (partially updated); consumers qualify reads with keys_valid.
REQ-023 Round counter SHALL be 4 bits, never exceeding ROUNDS; no wrap-around occurs.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, round counter 0, all slots zero, done 0, keys_valid 0, busy 0; key_ready = 1.
REQ-025 Reset mid-EXPAND SHALL abandon the schedule; no done pulse is issued and no partial keys remain.
REQ-026 After rst_n rises, the first accept edge behaves as REQ-013.

Configuration
REQ-027 Macro KEY_EXPANDER_ZEROIZE_EN defined: add input zeroize (1 bit); zeroize high at a rising edge SHALL clear all slots, keys_valid, done and counter and force IDLE, with priority over a simultaneous accept.
REQ-028 Macro undefined: no zeroize port; key material is cleared only by rst_n or overwritten by the next expansion.

Verification
REQ-029 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ROUNDS=10 -> done exactly 10 cycles after A0; rd_idx=1 gives a0fafe1788542cb123a339392a6c7605; rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rd_idx=0 returns the key.
REQ-030 key_valid held high through EXPAND with a changing key_in -> no second accept until IDLE; schedule matches the first key.
REQ-031 Second key offered in the done cycle -> accepted; keys_valid low next cycle; second schedule is correct; done pulses twice total.
REQ-032 rst_n pulsed low at A0+5 -> all outputs reset immediately, rd_key=0 for every index, no done pulse.
REQ-033 rd_idx=11..15 after completion -> rd_key all-zero; ROUNDS=4 build -> done at A0+4, rd_idx=5 returns zero.
REQ-034 With KEY_EXPANDER_ZEROIZE_EN: zeroize asserted together with key_valid in IDLE -> no accept, table zero, keys_valid 0.
